exe_mul_stage: RTL
==================

EXE_MUL_STAGE -- requirements
Module: exe_mul_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide ports: clk  in  1  rising-edge clock.
REQ-003 SHALL provide: rst  in  1  synchronous active-high reset.
REQ-004 SHALL provide: valid_in  in  1  ID/EX register holds a live instruction.
REQ-005 SHALL provide: EXE_CMD  in  4  op: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1111 MUL.
REQ-006 SHALL provide: Val1, Val2  in  32 each  operand A and shifter operand B; Val_Rm_in  in  32  store data.
REQ-007 SHALL provide: WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, S_IN  in  1 each; Dest_in  in  4; C_in  in  1  carry from status register.
REQ-008 SHALL provide: mem_ready  in  1  MEM stage Ready; low freezes this stage.
REQ-009 SHALL provide: stall_out  out  1  ID/EX register must hold.
REQ-010 SHALL provide registered: ALU_res, Val_Rm  out  32; Dest  out  4; WB_EN, MEM_R_EN, MEM_W_EN  out  1; status_out  out  4 (N,Z,C,V); status_wr  out  1.

Function
REQ-011 Output register SHALL load on an edge only when mem_ready=1; mem_ready=0 holds all outputs, state and counter.
REQ-012 Non-MUL op, valid_in=1, state IDLE: result SHALL appear on outputs 1 edge later (latency 1); stall_out=0.
REQ-013 valid_in=0 in IDLE: output register SHALL load a bubble (WB_EN, MEM_R_EN, MEM_W_EN, status_wr = 0).
REQ-014 ADC = A+B+C_in; SBC = A-B-(~C_in); arithmetic SHALL be 32-bit modulo 2^32.
REQ-015 N=res[31], Z=(res==0); C = carry-out for ADD/ADC, no-borrow for SUB/SBC, C_in otherwise; V = signed overflow for add/sub, 0 otherwise.
REQ-016 status_wr SHALL equal S_IN of the loaded instruction; bubbles give 0.
REQ-017 Memory ops pass address via ADD; Val_Rm_in SHALL propagate unchanged with the instruction.
REQ-018 States: IDLE, MUL_BUSY; 5-bit counter cnt.
REQ-019 IDLE + valid_in + MUL + mem_ready: SHALL latch Val1, Val2 and control, clear accumulator, cnt=0, enter MUL_BUSY; output register loads a bubble.
REQ-020 MUL_BUSY: each enabled edge SHALL do one shift-add iteration and increment cnt.
REQ-021 Edge with cnt=31: output register SHALL load low 32 bits of product with latched control; state -> IDLE (33 edges accept-to-result).
REQ-022 MUL flags: N,Z from product; C=C_in; V=0.
REQ-023 stall_out = ~mem_ready OR (IDLE AND valid_in AND MUL) OR (MUL_BUSY AND cnt!=31).
REQ-024 Changes on Val1/Val2/EXE_CMD during MUL_BUSY SHALL NOT affect the product.
REQ-025 Undefined EXE_CMD codes SHALL produce a bubble.

Reset
REQ-026 rst=1 on an edge SHALL force state IDLE, cnt=0, all outputs 0, regardless of mem_ready or multiply in progress.
REQ-027 Reset mid-multiply SHALL discard the partial product; no result is emitted.

Configuration
REQ-028 Macro EXE_MUL_EN SHALL compile in the iterative multiplier and MUL_BUSY state.
REQ-029 Without EXE_MUL_EN: 1111 SHALL be single-cycle, ALU_res=0, WB_EN=0, status_wr=0; stall_out = ~mem_ready only.

Verification
REQ-030 ADD Val1=32'h7FFFFFFF, Val2=1, S=1 -> next edge ALU_res=32'h80000000, status_out=N1 Z0 C0 V1, status_wr=1.
REQ-031 SUB 5-5, S=1 -> ALU_res=0, Z=1, C=1; then SBC 0-1, C_in=0 -> ALU_res=32'hFFFFFFFE, N=1, C=0.
REQ-032 MUL 32'd1234 x 32'd5678 -> stall_out high 32 cycles, edge 33 ALU_res=32'd7006652, WB_EN=1; intermediate outputs bubbles.
REQ-033 mem_ready=0 for 5 cycles mid-MUL -> outputs, cnt frozen, stall_out=1; result delayed exactly 5 edges.
REQ-034 rst=1 at cnt=10 of MUL -> next edge all outputs 0, IDLE, stall_out=0 with valid_in=0.
REQ-035 Build without EXE_MUL_EN, issue 1111 -> 1-edge latency, ALU_res=0, WB_EN=0, stall_out=0.

Source files
------------

// File: rtl/exe_mul_stage_if.sv
// Interface bundling the ID/EX-side inputs, MEM-stage ready and the EX/MEM
// output register of exe_mul_stage. The stage itself uses the slave modport.
interface exe_mul_stage_if;
    // ID/EX side
    logic        valid_in;
    logic [3:0]  EXE_CMD;
    logic [31:0] Val1;
    logic [31:0] Val2;
    logic [31:0] Val_Rm_in;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        S_IN;
    logic [3:0]  Dest_in;
    logic        C_in;
    // MEM stage ready, pipeline hold
    logic        mem_ready;
    logic        stall_out;
    // EX/MEM register
    logic [31:0] ALU_res;
    logic [31:0] Val_Rm;
    logic [3:0]  Dest;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [3:0]  status_out;
    logic        status_wr;

    modport master (
        output valid_in, EXE_CMD, Val1, Val2, Val_Rm_in, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               S_IN, Dest_in, C_in, mem_ready,
        input  stall_out, ALU_res, Val_Rm, Dest, WB_EN, MEM_R_EN, MEM_W_EN, status_out,
               status_wr
    );

    modport slave (
        input  valid_in, EXE_CMD, Val1, Val2, Val_Rm_in, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN,
               S_IN, Dest_in, C_in, mem_ready,
        output stall_out, ALU_res, Val_Rm, Dest, WB_EN, MEM_R_EN, MEM_W_EN, status_out,
               status_wr
    );
endinterface

// File: rtl/exe_mul_stage.sv
// Execute stage: single-cycle ALU plus an optional 32-iteration shift-add
// multiplier, feeding a registered EX/MEM output stage.
// Define EXE_MUL_EN to build the iterative multiplier and its MUL_BUSY state;
// without it, MUL (4'b1111) retires in one cycle as a bubble.
module exe_mul_stage (
    input  logic           clk,
    input  logic           rst,
    exe_mul_stage_if.slave bus
);

    localparam logic [3:0] CmdMov = 4'b0001;
    localparam logic [3:0] CmdMvn = 4'b1001;
    localparam logic [3:0] CmdAdd = 4'b0010;
    localparam logic [3:0] CmdAdc = 4'b0011;
    localparam logic [3:0] CmdSub = 4'b0100;
    localparam logic [3:0] CmdSbc = 4'b0101;
    localparam logic [3:0] CmdAnd = 4'b0110;
    localparam logic [3:0] CmdOrr = 4'b0111;
    localparam logic [3:0] CmdEor = 4'b1000;

    logic [32:0] sum;
    logic [31:0] alu_res;
    logic        alu_c;
    logic        alu_v;
    logic        alu_ok;

    logic [31:0] res_q, res_d;
    logic [31:0] rm_q, rm_d;
    logic [3:0]  dest_q, dest_d;
    logic        wb_q, wb_d;
    logic        mr_q, mr_d;
    logic        mw_q, mw_d;
    logic [3:0]  flags_q, flags_d;
    logic        swr_q, swr_d;

    // Single-cycle ALU; subtraction is A + ~B + 1 so carry-out means no borrow
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = bus.C_in;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (bus.EXE_CMD)
            CmdMov: alu_res = bus.Val2;
            CmdMvn: alu_res = ~bus.Val2;
            CmdAdd, CmdAdc: begin
                sum     = {1'b0, bus.Val1} + {1'b0, bus.Val2}
                        + {32'd0, (bus.EXE_CMD == CmdAdc) & bus.C_in};
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (bus.Val1[31] == bus.Val2[31]) && (alu_res[31] != bus.Val1[31]);
            end
            CmdSub, CmdSbc: begin
                sum     = {1'b0, bus.Val1} + {1'b0, ~bus.Val2}
                        + {32'd0, (bus.EXE_CMD == CmdSbc) ? bus.C_in : 1'b1};
                alu_res = sum[31:0];
                alu_c   = sum[32];
                alu_v   = (bus.Val1[31] != bus.Val2[31]) && (alu_res[31] != bus.Val1[31]);
            end
            CmdAnd: alu_res = bus.Val1 & bus.Val2;
            CmdOrr: alu_res = bus.Val1 | bus.Val2;
            CmdEor: alu_res = bus.Val1 ^ bus.Val2;
            default: alu_ok = 1'b0;  // undefined codes and MUL load a bubble here
        endcase
    end

`ifdef EXE_MUL_EN
    localparam logic [3:0] CmdMul = 4'b1111;

    typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] mcand_q, mplier_q, acc_q, acc_step;
    logic        mul_wb_q, mul_mr_q, mul_mw_q, mul_s_q, mul_c_q;
    logic [3:0]  mul_dest_q;
    logic [31:0] mul_rm_q;
    logic        mul_accept;

    assign mul_accept = (state_q == StIdle) && bus.valid_in && (bus.EXE_CMD == CmdMul);
    // Multiplicand shifts left and multiplier right, so bit 0 selects each partial
    assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    // State register and iteration counter, frozen while MEM is not ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (bus.mem_ready) begin
            state_q <= state_d;
            cnt_q   <= (state_q == StMulBusy) ? cnt_q + 5'd1 : 5'd0;
        end
    end

    // Next-state: accept a MUL from IDLE, leave after the 32nd iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (mul_accept) state_d = StMulBusy;
            StMulBusy: if (cnt_q == 5'd31) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Operand/control latch and shift-add datapath; isolates MUL from ID/EX changes
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_wb_q   <= 1'b0;
            mul_mr_q   <= 1'b0;
            mul_mw_q   <= 1'b0;
            mul_s_q    <= 1'b0;
            mul_c_q    <= 1'b0;
            mul_dest_q <= '0;
            mul_rm_q   <= '0;
        end else if (bus.mem_ready) begin
            if (mul_accept) begin
                mcand_q    <= bus.Val1;
                mplier_q   <= bus.Val2;
                acc_q      <= '0;
                mul_wb_q   <= bus.WB_EN_IN;
                mul_mr_q   <= bus.MEM_R_EN_IN;
                mul_mw_q   <= bus.MEM_W_EN_IN;
                mul_s_q    <= bus.S_IN;
                mul_c_q    <= bus.C_in;
                mul_dest_q <= bus.Dest_in;
                mul_rm_q   <= bus.Val_Rm_in;
            end else if (state_q == StMulBusy) begin
                acc_q    <= acc_step;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
        end
    end

    assign bus.stall_out = ~bus.mem_ready | mul_accept
                         | ((state_q == StMulBusy) && (cnt_q != 5'd31));
`else
    assign bus.stall_out = ~bus.mem_ready;
`endif

    // Output-register next value: MUL result on its last iteration, else ALU or bubble
    always_comb begin
        res_d   = '0;
        rm_d    = '0;
        dest_d  = '0;
        wb_d    = 1'b0;
        mr_d    = 1'b0;
        mw_d    = 1'b0;
        flags_d = '0;
        swr_d   = 1'b0;
`ifdef EXE_MUL_EN
        if (state_q == StMulBusy) begin
            if (cnt_q == 5'd31) begin
                res_d   = acc_step;
                rm_d    = mul_rm_q;
                dest_d  = mul_dest_q;
                wb_d    = mul_wb_q;
                mr_d    = mul_mr_q;
                mw_d    = mul_mw_q;
                flags_d = {acc_step[31], acc_step == 32'd0, mul_c_q, 1'b0};
                swr_d   = mul_s_q;
            end
        end else
`endif
        if (bus.valid_in && alu_ok) begin
            res_d   = alu_res;
            rm_d    = bus.Val_Rm_in;
            dest_d  = bus.Dest_in;
            wb_d    = bus.WB_EN_IN;
            mr_d    = bus.MEM_R_EN_IN;
            mw_d    = bus.MEM_W_EN_IN;
            flags_d = {alu_res[31], alu_res == 32'd0, alu_c, alu_v};
            swr_d   = bus.S_IN;
        end
    end

    // EX/MEM register: reset wins, otherwise loads only when MEM is ready
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q   <= '0;
            rm_q    <= '0;
            dest_q  <= '0;
            wb_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            flags_q <= '0;
            swr_q   <= 1'b0;
        end else if (bus.mem_ready) begin
            res_q   <= res_d;
            rm_q    <= rm_d;
            dest_q  <= dest_d;
            wb_q    <= wb_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            flags_q <= flags_d;
            swr_q   <= swr_d;
        end
    end

    assign bus.ALU_res    = res_q;
    assign bus.Val_Rm     = rm_q;
    assign bus.Dest       = dest_q;
    assign bus.WB_EN      = wb_q;
    assign bus.MEM_R_EN   = mr_q;
    assign bus.MEM_W_EN   = mw_q;
    assign bus.status_out = flags_q;
    assign bus.status_wr  = swr_q;

endmodule
